// File: rtl/lcd_pkg.sv
// Shared state encoding, HD44780 command bytes and power-on init ROM for the LCD sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_LOAD,
        IDLE,
        SETUP,
        E_HIGH,
        WAIT
    } lcd_state_e;

    localparam logic [7:0] LCD_CLEAR        = 8'h01;
    localparam logic [7:0] LCD_HOME         = 8'h02;
    localparam logic [7:0] LCD_ENTRY        = 8'h06;
    localparam logic [7:0] LCD_DISP_ON      = 8'h0C;
    localparam logic [7:0] LCD_FUNC_8BIT_2L = 8'h38;

    localparam int unsigned INIT_LEN = 6;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0, 3'd1, 3'd2: b = LCD_FUNC_8BIT_2L;
            3'd3:             b = LCD_DISP_ON;
            3'd4:             b = LCD_CLEAR;
            3'd5:             b = LCD_ENTRY;
            default:          b = LCD_FUNC_8BIT_2L;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_tick_counter.sv
// Counts timer ticks while enabled; done once the count reaches the target (a target of 0 acts as 1).
module lcd_tick_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic       tick,
    input  logic [7:0] target,
    output logic       done
);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && tick && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q >= ((target == 8'd0) ? 8'd1 : target));

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// HD44780 bus sequencer: power-on init (when LCD_INIT_SEQ_EN is defined), then upstream bytes
// paced by the tick timer. Without LCD_INIT_SEQ_EN the FSM drops straight into IDLE after reset.
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned E_PULSE_TICKS    = 1,
    parameter int unsigned CMD_WAIT_TICKS   = 1,
    parameter int unsigned CLEAR_WAIT_TICKS = 20,
    parameter int unsigned POWERUP_TICKS    = 150
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       tick,
    output logic       timer_en,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    lcd_state_e state_q, state_d;
    logic       init_done_q, init_done_d;
    logic       lcd_rs_q, lcd_rs_d;
    logic [7:0] lcd_data_q, lcd_data_d;
    logic       timer_en_q, timer_en_d;
    logic       req_ready_q, req_ready_d;
    logic       lcd_e_q, lcd_e_d;
    logic       entry_q, state_change;
    logic       long_wait;
    logic [7:0] tick_target;
    logic       tick_done;
`ifdef LCD_INIT_SEQ_EN
    logic [2:0] idx_q, idx_d;
`endif

    assign long_wait = !lcd_rs_q && (lcd_data_q[7:1] == 7'h00);

    always_comb begin
        case (state_q)
            PWR_WAIT: tick_target = 8'(POWERUP_TICKS);
            E_HIGH:   tick_target = 8'(E_PULSE_TICKS);
            WAIT:     tick_target = long_wait ? 8'(CLEAR_WAIT_TICKS) : 8'(CMD_WAIT_TICKS);
            default:  tick_target = 8'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        init_done_d = init_done_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_data_d  = lcd_data_q;
`ifdef LCD_INIT_SEQ_EN
        idx_d       = idx_q;
`endif
        case (state_q)
            PWR_WAIT: begin
`ifdef LCD_INIT_SEQ_EN
                if (tick_done) state_d = INIT_LOAD;
`else
                state_d     = IDLE;
                init_done_d = 1'b1;
`endif
            end
            INIT_LOAD: begin
`ifdef LCD_INIT_SEQ_EN
                lcd_rs_d   = 1'b0;
                lcd_data_d = init_rom(idx_q);
                idx_d      = idx_q + 3'd1;
                state_d    = SETUP;
`else
                state_d    = IDLE;
`endif
            end
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    lcd_rs_d   = req_rs;
                    lcd_data_d = req_data;
                    state_d    = SETUP;
                end
            end
            SETUP:  state_d = E_HIGH;
            E_HIGH: if (tick_done) state_d = WAIT;
            WAIT: begin
                if (tick_done) begin
`ifdef LCD_INIT_SEQ_EN
                    if (!init_done_q && (idx_q < 3'(INIT_LEN))) begin
                        state_d = INIT_LOAD;
                    end else begin
                        state_d     = IDLE;
                        init_done_d = 1'b1;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = PWR_WAIT;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q and reset cleanly to 0.
    always_comb begin
        timer_en_d   = (state_d == PWR_WAIT) || (state_d == E_HIGH) || (state_d == WAIT);
        req_ready_d  = (state_d == IDLE);
        lcd_e_d      = (state_d == E_HIGH);
        state_change = (state_d != state_q);
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q     <= PWR_WAIT;
            init_done_q <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= 8'h00;
            timer_en_q  <= 1'b0;
            req_ready_q <= 1'b0;
            lcd_e_q     <= 1'b0;
            entry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_done_q <= init_done_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_data_q  <= lcd_data_d;
            timer_en_q  <= timer_en_d;
            req_ready_q <= req_ready_d;
            lcd_e_q     <= lcd_e_d;
            entry_q     <= state_change;
        end
    end

`ifdef LCD_INIT_SEQ_EN
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end
`endif

    // Count clears on the transition edge; entry_q masks a tick landing in the first cycle of a state.
    lcd_tick_counter u_tick_counter (
        .clk    (clock),
        .rst_n  (rst),
        .clear  (state_change),
        .en     (timer_en_q && !entry_q),
        .tick   (tick),
        .target (tick_target),
        .done   (tick_done)
    );

    assign timer_en  = timer_en_q;
    assign req_ready = req_ready_q;
    assign init_done = init_done_q;
    assign lcd_e     = lcd_e_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_data  = lcd_data_q;

endmodule

// File: doc/lcd_cmd_sequencer.md
# lcd_cmd_sequencer

Sequences the 100 us tick timer and the HD44780-style LCD bus. It runs the power-on init sequence, then accepts command and data bytes from the upstream display logic over a valid/ready handshake. Each byte is driven onto the LCD pins with a timer-paced enable pulse and a settle wait. The block is the only owner of the tick timer's enable input; it sits between the text/cursor logic and the LCD pads.

## Interface
- E_PULSE_TICKS, 1 — ticks lcd_e is held high per transfer
- CMD_WAIT_TICKS, 1 — ticks waited after a normal command or data write
- CLEAR_WAIT_TICKS, 20 — ticks waited after clear (0x01) or home (0x02)
- POWERUP_TICKS, 150 — ticks waited after reset before the first init write
- clock  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle pulse from tick timer, nominally every 100 us
- timer_en  out  1  enable to tick timer (EnableCount)
- req_valid  in  1  upstream byte valid
- req_rs  in  1  0 = command, 1 = data
- req_data  in  8  byte to write
- req_ready  out  1  block can accept a byte this cycle
- init_done  out  1  init sequence complete; sticky until reset
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  constant 0 (write-only)
- lcd_data  out  8  LCD data bus

## Operation
- FSM states:
  - PWR_WAIT: counting POWERUP_TICKS, then → INIT_LOAD.
  - INIT_LOAD: loads init ROM entry and index, then → SETUP.
  - IDLE: req_ready=1; on req_valid&&req_ready latch rs/data, then → SETUP.
  - SETUP: one cycle, lcd_rs/lcd_data valid, lcd_e=0, then → E_HIGH.
  - E_HIGH: lcd_e=1; after E_PULSE_TICKS ticks → WAIT.
  - WAIT: lcd_e=0; after the wait count → INIT_LOAD if init entries remain, IDLE if init is done, or IDLE and set init_done after the last init entry.
- Wait selection: rs=0 and data[7:1]==7'h00 (clear/home) uses CLEAR_WAIT_TICKS; everything else uses CMD_WAIT_TICKS.
- Init ROM order: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, all rs=0.
- timer_en=1 only in PWR_WAIT, E_HIGH and WAIT. The tick counter clears on every state entry. Ticks arriving while timer_en=0 are ignored.
- Tick counter is 8 bits unsigned. A parameter value of 0 behaves as 1. Parameters must be ≤255.
- lcd_rs and lcd_data hold their last value in IDLE and change only on entry to SETUP.

## Timing
- Reset values: timer_en=0, req_ready=0, init_done=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, state=PWR_WAIT. Reset is asynchronous, so lcd_e drops immediately, including mid-pulse.
- Handshake: a byte is accepted in the cycle with req_valid&&req_ready high. req_ready goes low the next cycle. req_valid held high during busy states is ignored; no byte is lost or duplicated.
- Accept-to-lcd_e-rise latency is 2 cycles (SETUP, then E_HIGH).
- Return to IDLE occurs in the cycle after the final wait tick is counted. req_ready rises that same cycle.
- A tick in the same cycle as a state entry is not counted.

## Configuration
- LCD_INIT_SEQ_EN defined: behaviour as above.
- LCD_INIT_SEQ_EN undefined: no init ROM and no PWR_WAIT/INIT_LOAD states. After reset the FSM goes straight to IDLE with init_done=1 and req_ready=1 one cycle after reset release. Upstream logic is then responsible for init.

## Structure
- Package lcd_pkg holds:
  - the state encoding constants
  - LCD command constants (CLEAR=0x01, HOME=0x02, ENTRY=0x06, DISP_ON=0x0C, FUNC_8BIT_2L=0x38)
  - init ROM length (6)
- Sub-module lcd_tick_counter: clear/enable/tick inputs, 8-bit count, `done` output when count ≥ max(target,1).

## Test plan
- Reset with macro on, tick every 10 cycles: init_done rises only after 150 + 6 × (1+1) + 19 extra clear-wait ticks. lcd_data shows 0x38,0x38,0x38,0x0C,0x01,0x06 on the six lcd_e rises.
- After init, rs=1 data=0x41: lcd_e rises 2 cycles after accept; lcd_rs=1 and lcd_data=0x41 are stable while lcd_e=1; req_ready returns after 2 ticks.
- Command 0x01: WAIT lasts 20 ticks; a req_valid held high meanwhile is accepted exactly once, after req_ready rises.
- Ticks injected while IDLE: no state change, timer_en stays 0.
- Reset asserted while lcd_e=1: lcd_e=0 asynchronously; the FSM restarts in PWR_WAIT and init_done=0.
- Macro off: req_ready=1 one cycle after reset release; the first write reaches the LCD with no power-up wait.
